// File: rtl/midi_pkg.sv
// Shared MIDI constants: status nibbles, UART state encoding, register offsets
// and the data-byte count per channel-voice message.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  localparam logic [11:0] OFS_DATA   = 12'd0;
  localparam logic [11:0] OFS_STATUS = 12'd1;

  function automatic logic [1:0] data_bytes(input logic [3:0] hi);
    case (hi)
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: data_bytes = 2'd2;
      PROG, CH_AT:                           data_bytes = 2'd1;
      default:                               data_bytes = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_rx_mmio_uart_rx_byte.sv
// 8N1 serial byte receiver: 2-flop synchronizer plus start/data/stop FSM,
// emitting one byte_valid pulse per correctly framed byte.
module uart_rx_byte
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       midi_in,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          sync_p0, sync_p1, rx_prev;
  uart_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shreg, shreg_next;
  logic          emit;

  // Synchronizer and edge history reset low so a line held low through
  // reset must first return high before a start edge is recognised.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      rx_prev    <= 1'b0;
      state      <= UART_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else begin
      sync_p0    <= midi_in;
      sync_p1    <= sync_p0;
      rx_prev    <= sync_p1;
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_next;
      shreg      <= shreg_next;
      byte_valid <= emit;
      if (emit) byte_data <= shreg;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    bit_next   = bit_idx;
    shreg_next = shreg;
    emit       = 1'b0;
    case (state)
      UART_IDLE: begin
        cnt_next = '0;
        if (rx_prev && !sync_p1) state_next = UART_START;
      end
      UART_START: begin
        if (cnt == MID) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = sync_p1 ? UART_IDLE : UART_DATA;
        end
      end
      UART_DATA: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          shreg_next = {sync_p1, shreg[7:1]};
          bit_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = UART_STOP;
        end
      end
      UART_STOP: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          emit       = sync_p1;
          state_next = UART_IDLE;
        end
      end
      default: state_next = UART_IDLE;
    endcase
  end

endmodule

// File: rtl/midi_rx_mmio.sv
// MIDI receiver with channel-voice parser, message FIFO and two read-only
// memory-mapped registers (DATA pops the FIFO, STATUS clears overflow).
module midi_rx_mmio
  import midi_pkg::*;
#(
  parameter int          CLK_HZ     = 50000000,
  parameter int          BAUD       = 31250,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [11:0] BASE_ADDR  = 12'hF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        midi_in,
  input  logic [11:0] addr,
  input  logic        rd_en,
  output logic [31:0] q,
  output logic        msg_valid,
  output logic        overflow
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  logic [7:0] byte_data;
  logic       byte_valid;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clock      (clock),
    .reset      (reset),
    .midi_in    (midi_in),
    .byte_data  (byte_data),
    .byte_valid (byte_valid)
  );

  logic [7:0]  run_status, d1;
  logic        have_d1;
  logic        is_data, msg_done, push;
  logic [31:0] push_word;

  assign is_data  = byte_valid && !byte_data[7] && run_status[7];
  assign msg_done = is_data && (have_d1 || data_bytes(run_status[7:4]) == 2'd1);
  assign push     = msg_done;
  assign push_word = have_d1 ? {8'h00, run_status, d1, byte_data}
                             : {8'h00, run_status, byte_data, 8'h00};

  // Running status survives realtime bytes; system common bytes cancel it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_status <= '0;
      have_d1    <= 1'b0;
      d1         <= '0;
    end else if (byte_valid) begin
      if (byte_data >= 8'hF8) begin
        run_status <= run_status;
      end else if (byte_data >= 8'hF0) begin
        run_status <= '0;
        have_d1    <= 1'b0;
      end else if (byte_data[7]) begin
        run_status <= byte_data;
        have_d1    <= 1'b0;
      end else if (is_data) begin
        if (msg_done) begin
          have_d1 <= 1'b0;
        end else begin
          have_d1 <= 1'b1;
          d1      <= byte_data;
        end
      end
    end
  end

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          full, rd_data, rd_stat, pop, wr, drop;

  assign full      = (count == NW'(FIFO_DEPTH));
  assign msg_valid = (count != '0);
  assign rd_data   = rd_en && (addr == BASE_ADDR + OFS_DATA);
  assign rd_stat   = rd_en && (addr == BASE_ADDR + OFS_STATUS);
  assign pop       = rd_data && msg_valid;
  assign wr        = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      q        <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop on the same edge as a STATUS read keeps the flag set.
      if (drop)         overflow <= 1'b1;
      else if (rd_stat) overflow <= 1'b0;
      if (rd_data)      q <= msg_valid ? mem[rd_ptr] : 32'h0;
      else if (rd_stat) q <= {29'b0, overflow, full, msg_valid};
      else              q <= 32'h0;
    end
  end

endmodule

// File: tb/tb_midi_rx_mmio.sv
// Scoreboard bench for midi_rx_mmio at 16 clocks per bit: serial stimulus,
// expected FIFO words queued as messages complete, checked on DATA reads.
module tb_midi_rx_mmio;

  localparam logic [11:0] BASE = 12'hF00;

  logic        clock = 1'b0;
  logic        reset;
  logic        midi_in;
  logic [11:0] addr;
  logic        rd_en;
  logic [31:0] q;
  logic        msg_valid;
  logic        overflow;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] expq [$];
  logic [31:0] r;

  always #5 clock = ~clock;

  midi_rx_mmio #(
    .CLK_HZ     (16),
    .BAUD       (1),
    .FIFO_DEPTH (8),
    .BASE_ADDR  (BASE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .midi_in   (midi_in),
    .addr      (addr),
    .rd_en     (rd_en),
    .q         (q),
    .msg_valid (msg_valid),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    midi_in = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      repeat (16) @(negedge clock);
    end
    midi_in = stop_bit;
    repeat (16) @(negedge clock);
    midi_in = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic read_reg(input logic [11:0] a, output logic [31:0] rv);
    @(negedge clock);
    addr  = a;
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    addr  = '0;
    rv    = q;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] rv, exp;
    exp = (expq.size() != 0) ? expq.pop_front() : 32'h0;
    read_reg(BASE, rv);
    check(tag, rv, exp);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!msg_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    check(tag, {31'b0, msg_valid}, 32'h1);
  endtask

  initial begin
    reset   = 1'b0;
    midi_in = 1'b1;
    rd_en   = 1'b0;
    addr    = '0;
    repeat (3) @(negedge clock);
    check("rst_q", q, 32'h0);
    check("rst_valid", {31'b0, msg_valid}, 32'h0);
    check("rst_ovf", {31'b0, overflow}, 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // Plain note-on
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    expq.push_back(32'h00903C64);
    send_byte(8'h64, 1'b1);
    wait_valid("noteon_valid");
    read_data("noteon_data");
    check("noteon_drained", {31'b0, msg_valid}, 32'h0);
    @(negedge clock);
    check("q_idle", q, 32'h0);

    // Running status
    send_byte(8'h90, 1'b1);
    send_byte(8'h40, 1'b1);
    expq.push_back(32'h0090407F);
    send_byte(8'h7F, 1'b1);
    send_byte(8'h43, 1'b1);
    expq.push_back(32'h00904300);
    send_byte(8'h00, 1'b1);
    read_data("rs_first");
    read_data("rs_second");
    check("rs_drained", {31'b0, msg_valid}, 32'h0);

    // Program change with a realtime clock byte in the middle
    send_byte(8'hC5, 1'b1);
    send_byte(8'hF8, 1'b1);
    expq.push_back(32'h00C51000);
    send_byte(8'h10, 1'b1);
    wait_valid("prog_valid");
    read_data("prog_data");
    read_data("empty_data");
    check("prog_drained", {31'b0, msg_valid}, 32'h0);

    // Stray data after reset, then a framing error on a status byte
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    send_byte(8'h40, 1'b1);
    send_byte(8'h90, 1'b0);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    check("stray_valid", {31'b0, msg_valid}, 32'h0);
    read_reg(BASE + 12'd1, r);
    check("stray_status", r, 32'h0);

    // Nine messages into an eight-deep FIFO
    send_byte(8'h90, 1'b1);
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h30 + 8'(i), 1'b1);
      if (i < 8) expq.push_back({8'h00, 8'h90, 8'h30 + 8'(i), 8'h40 + 8'(i)});
      send_byte(8'h40 + 8'(i), 1'b1);
    end
    check("ovf_flag", {31'b0, overflow}, 32'h1);
    read_reg(BASE + 12'd1, r);
    check("ovf_status1", r, 32'h7);
    read_reg(BASE + 12'd1, r);
    check("ovf_status2", r, 32'h3);
    for (int i = 0; i < 8; i++) read_data($sformatf("ovf_data%0d", i));
    check("ovf_drained", {31'b0, msg_valid}, 32'h0);
    read_reg(BASE + 12'd1, r);
    check("ovf_status3", r, 32'h0);

    // Reset in the middle of a data byte, line held low through release
    send_byte(8'h90, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_valid("pre_reset_valid");
    send_byte(8'h80, 1'b1);
    @(negedge clock);
    midi_in = 1'b0;
    repeat (16) @(negedge clock);
    midi_in = 1'b0;
    repeat (24) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_valid", {31'b0, msg_valid}, 32'h0);
    check("midrst_q", q, 32'h0);
    check("midrst_ovf", {31'b0, overflow}, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    midi_in = 1'b1;
    repeat (10) @(negedge clock);
    check("postrst_valid", {31'b0, msg_valid}, 32'h0);
    send_byte(8'h80, 1'b1);
    send_byte(8'h3C, 1'b1);
    expq.push_back(32'h00803C00);
    send_byte(8'h00, 1'b1);
    wait_valid("postrst_msg_valid");
    read_data("postrst_data");
    check("postrst_drained", {31'b0, msg_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
